// File: rtl/fb_pixel_writer.sv
// Renderer pixel sink: buffers on-screen pixels in a FIFO, drains them to the framebuffer through req/gnt.
// Accept-to-mem_we is 3 cycles with grant held; in_ready drops while the FIFO is full.

module fb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_vld,
    output logic                   push_rdy,
    input  logic [WIDTH-1:0]       push_dat,
    output logic                   pop_vld,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0] count
);
    // Generic circular-buffer FIFO with occupancy counter.
    // Zero-latency head visibility; push_rdy is low when full, regardless of a same-cycle pop.

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             push_fire, pop_fire;

    always_comb begin
        push_rdy  = (count_q != FULL_CNT);
        pop_vld   = (count_q != '0);
        pop_dat   = mem_q[rd_ptr_q];
        count     = count_q;
        push_fire = push_vld & push_rdy;
        pop_fire  = pop_rdy & pop_vld;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the counter says they are valid.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

module fb_pixel_writer #(
    parameter int COLOR_W  = 3,
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [8:0]         in_x,
    input  logic [7:0]         in_y,
    input  logic [COLOR_W-1:0] in_color,
    output logic               in_ready,
    output logic               mem_req,
    input  logic               mem_gnt,
    output logic               mem_we,
    output logic [16:0]        mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    output logic               idle,
    output logic [15:0]        drop_count
);
    // Coordinate-to-address conversion, off-screen filtering and grant-driven drain FSM.
    // Pops only in cycles with mem_gnt high, so a grant drop leaves the head queued.

    localparam int ENT_W = 17 + COLOR_W;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [8:0] X_LIM = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_GNT,
        S_WRITE
    } state_t;

    state_t           state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic [15:0]      drop_count_q, drop_count_d;

    logic             on_screen;
    logic             accept;
    logic             push_vld;
    logic             push_rdy;
    logic             pop_vld;
    logic             last_pop;
    logic [16:0]      lin_addr;
    logic [ENT_W-1:0] head_dat;
    logic [CW-1:0]    fifo_count;

    always_comb begin
        on_screen = (in_x < X_LIM) && (in_y < Y_LIM);
        // y*320 as y*256 + y*64, all terms widened to 17 bits before the add.
        lin_addr  = {1'b0, in_y, 8'b0} + {3'b0, in_y, 6'b0} + {8'b0, in_x};
        in_ready  = push_rdy & ~reset;
        accept    = in_valid & in_ready;
        push_vld  = accept & on_screen;

        mem_we    = (state_q == S_WRITE) & mem_gnt & pop_vld & ~reset;
        mem_addr  = mem_we ? head_dat[ENT_W-1:COLOR_W] : '0;
        mem_data  = mem_we ? head_dat[COLOR_W-1:0] : '0;
        mem_req   = mem_req_q;
        idle      = ~pop_vld & (state_q == S_IDLE);
        drop_count = drop_count_q;

        last_pop  = mem_we & ~push_vld & (fifo_count == CW'(1));

        drop_count_d = drop_count_q;
        if (accept && !on_screen && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    fb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_rdy (push_rdy),
        .push_dat ({lin_addr, in_color}),
        .pop_vld  (pop_vld),
        .pop_rdy  (mem_we),
        .pop_dat  (head_dat),
        .count    (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop_vld) begin
                    state_d = S_WAIT_GNT;
                end
            end
            S_WAIT_GNT: begin
                if (mem_gnt) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Leaving on the last pop lets idle rise right after the FIFO empties.
                if (!mem_gnt || !pop_vld || last_pop) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        mem_req_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            drop_count_q <= drop_count_d;
        end
    end

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Sink for the renderer pixel stream (`x`, `y`, `color`, write strobe) that buffers accepted pixels in a small FIFO and writes them into the shared 320x240 framebuffer memory through a request/grant port. It sits between the rendering blocks and the framebuffer arbiter. It converts screen coordinates to linear addresses, discards off-screen pixels, and applies backpressure to the producer when full.

## Interface
- `COLOR_W`, 3, pixel color width
- `DEPTH`, 16, FIFO entries; power of two, >= 2
- `SCREEN_W`, 320, visible width in pixels
- `SCREEN_H`, 240, visible height in pixels

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock (50 MHz)
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  pixel present (renderer write enable)
- `in_x`  in  9  pixel x
- `in_y`  in  8  pixel y
- `in_color`  in  COLOR_W  pixel color
- `in_ready`  out  1  pixel accepted when `in_valid & in_ready`
- `mem_req`  out  1  request framebuffer access
- `mem_gnt`  in  1  arbiter grant; may drop at any cycle
- `mem_we`  out  1  framebuffer write strobe
- `mem_addr`  out  17  linear address, y*SCREEN_W + x
- `mem_data`  out  COLOR_W  write data
- `idle`  out  1  FIFO empty and FSM in IDLE
- `drop_count`  out  16  saturating count of discarded off-screen pixels

## Operation
- Accept: on `in_valid & in_ready`:
  - If `in_x < SCREEN_W` and `in_y < SCREEN_H`, push {addr, color}.
    - addr = (in_y<<8) + (in_y<<6) + in_x, computed at 17 bits. No truncation; max is 76799.
  - Otherwise do not push. Increment `drop_count`, saturating at 16'hFFFF.
- `in_ready` = ~full. A push is refused when full even if a pop occurs in the same cycle.
- FIFO: circular read/write pointers of log2(DEPTH) bits, wrapping at DEPTH. Occupancy counter of log2(DEPTH)+1 bits. Push and pop in the same cycle leave occupancy unchanged.
- Drain FSM, states IDLE, WAIT_GNT, WRITE:
  - IDLE: FIFO non-empty -> WAIT_GNT.
  - WAIT_GNT: `mem_gnt`=1 -> WRITE; otherwise stay.
  - WRITE: `mem_we` = `mem_gnt` & ~empty. Each `mem_we` cycle pops the head. `mem_gnt`=0 or FIFO empty -> IDLE.
- `mem_req` = 1 in WAIT_GNT and WRITE.
- `mem_addr`/`mem_data` = FIFO head when `mem_we`=1, else 0.
- No pixel is ever lost or reordered after acceptance. A grant drop in WRITE leaves the head in place, and it is written after re-grant.

## Timing
- Reset values: `in_ready`=0 while `reset` is high, then 1. `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `idle`=1, `drop_count`=0. FIFO is emptied and the FSM is in IDLE.
- Reset mid-burst discards all queued pixels and returns the FSM to IDLE on the next edge.
- Latency, pixel accepted at edge N with `mem_gnt` held high:
  - FIFO non-empty after N.
  - FSM in WAIT_GNT after N+1 (`mem_req`=1).
  - FSM in WRITE after N+2; `mem_we` asserted in that cycle.
- Throughput: one write per cycle while in WRITE with grant held and FIFO non-empty. Back-to-back pushes and pops are sustained at full rate.
- `mem_gnt` is sampled each cycle. Deassertion in a WRITE cycle suppresses `mem_we` in that cycle; the FSM goes to IDLE, then WAIT_GNT.
- Full boundary: with DEPTH entries queued, `in_ready`=0. It returns to 1 the cycle after the first pop.
- Empty boundary: `idle` rises the cycle after the last pop once the FSM is in IDLE.
- A drop and a push never occur together, since at most one pixel is offered per cycle.

## Test plan
- Single pixel (x=5, y=2, color=3), `mem_gnt` tied 1 -> exactly one `mem_we`, 3 cycles after acceptance, with `mem_addr`=645 and `mem_data`=3. `idle` returns to 1.
- Corner pixels (0,0) and (319,239) -> addresses 0 and 76799. Pixels (320,0) and (0,240) -> no writes and `drop_count`=2.
- `mem_gnt`=0 while 20 pixels are offered -> 16 accepted; `in_ready`=0 after the 16th. Grant then held high -> 16 consecutive `mem_we` in order, then the remaining 4 pixels are accepted and written.
- A 40x30 rectangle stream from the renderer with `mem_gnt` toggling pseudo-randomly -> 1200 writes with exact address/data order. No `mem_we` occurs when `mem_gnt`=0.
- `reset` pulsed with 8 pixels queued -> no further `mem_we`; `idle`=1, `drop_count`=0, `in_ready`=1 the cycle after reset deasserts.
- 70000 off-screen pixels -> `drop_count` saturates at 65535 and holds.
